// File: rtl/servo_axil_pkg.sv
// Shared register map, response codes, control bitfield and FSM state types
// for the servo PWM AXI4-Lite peripheral.
package servo_axil_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PULSE   = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [30:0] rsvd;
    logic        enable;
  } ctrl_t;

  typedef enum logic [0:0] {StWrIdle, StWrResp} wr_state_e;
  typedef enum logic [0:0] {StRdIdle, StRdValid} rd_state_e;

  // Merge new_val into old_val on the byte lanes enabled by strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo PWM counter and comparator. Defining SERVO_SHADOW_EN makes period and
// pulse changes take effect only at period boundaries via active copies.
module servo_pwm_gen
  import servo_axil_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  input  logic [31:0] pulse_i,
  output logic        pwm_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_act, pul_act;
  logic        pwm_q, pwm_d;
  logic        running;

`ifdef SERVO_SHADOW_EN
  logic [31:0] per_act_q, pul_act_q;
  logic        load;

  assign per_act = per_act_q;
  assign pul_act = pul_act_q;
  // Reload at the last count of a period, or freely while idle.
  assign load    = !running || (cnt_q == per_act_q - 32'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_act_q <= '0;
      pul_act_q <= '0;
    end else if (load) begin
      per_act_q <= period_i;
      pul_act_q <= pulse_i;
    end
  end
`else
  assign per_act = period_i;
  assign pul_act = pulse_i;
`endif

  assign running = enable_i && (per_act != '0);

  always_comb begin
    cnt_d = '0;
    // >= also covers a period shrunk below the current count.
    if (running && (cnt_q < per_act - 32'd1)) cnt_d = cnt_q + 32'd1;
    pwm_d = running && (cnt_q < pul_act);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_axil_slave.sv
// AXI4-Lite responder for the servo PWM peripheral: four 32-bit registers
// (CTRL, PERIOD, PULSE, SCRATCH) feeding servo_pwm_gen.
module servo_axil_slave
  import servo_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out
);

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];
  logic [31:0] rdata_q, rdata_d;

  logic        bvalid, rvalid;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  ctrl_t       ctrl;
  logic        unused;

  assign bvalid = (wr_state_q == StWrResp);
  assign rvalid = (rd_state_q == StRdValid);

  // Readies are gated by ARESET so they first appear the cycle after release.
  assign S_AXI_AWREADY = !ARESET && !aw_held_q && !bvalid;
  assign S_AXI_WREADY  = !ARESET && !w_held_q && !bvalid;
  assign S_AXI_ARREADY = !ARESET && !rvalid;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    regs_d     = regs_q;
    unique case (wr_state_q)
      StWrIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = S_AXI_WDATA;
          w_strb_d = S_AXI_WSTRB;
        end
        if (commit) begin
          regs_d[wr_idx] = apply_strb(regs_q[wr_idx], wr_data, wr_strb);
          wr_state_d     = StWrResp;
        end
      end
      StWrResp: begin
        if (S_AXI_BREADY) begin
          wr_state_d = StWrIdle;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = StWrIdle;
    endcase
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      StRdIdle: begin
        if (ar_hs) begin
          rdata_d    = regs_q[S_AXI_ARADDR[3:2]];
          rd_state_d = StRdValid;
        end
      end
      StRdValid: begin
        if (S_AXI_RREADY) rd_state_d = StRdIdle;
      end
      default: rd_state_d = StRdIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= StWrIdle;
      rd_state_q <= StRdIdle;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = AXI_RESP_OKAY;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RRESP  = AXI_RESP_OKAY;
  assign S_AXI_RDATA  = rdata_q;

  assign ctrl = regs_q[ADDR_CTRL];

  servo_pwm_gen u_pwm_gen (
    .clk_i    (ACLK),
    .rst_i    (ARESET),
    .enable_i (ctrl.enable),
    .period_i (regs_q[ADDR_PERIOD]),
    .pulse_i  (regs_q[ADDR_PULSE]),
    .pwm_o    (pwm_out)
  );

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                    ctrl.rsvd};

endmodule

// File: tb/tb_servo_axil_slave.sv
// Directed self-checking bench for servo_axil_slave.
module tb_servo_axil_slave;

`ifdef SERVO_SHADOW_EN
  localparam bit Shadow = 1'b1;
`else
  localparam bit Shadow = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  servo_axil_slave dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .pwm_out       (pwm_out)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hit, w_hit, got;
    int n;
    aw_done = 0; w_done = 0; got = 0; n = 0; resp = 2'bxx;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge ACLK);
      aw_hit = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hit  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hit) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hit) begin S_AXI_WVALID = 1'b0; w_done = 1; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!got && n < 20) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin got = 1; resp = S_AXI_BRESP; end
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_BREADY = 1'b0;
    if (!got) check("write_timeout", 64'd0, 64'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit done, hit, got;
    int n;
    done = 0; got = 0; n = 0; lat = 0; data = 'x; resp = 2'bxx;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!done && n < 20) begin
      @(negedge ACLK);
      hit = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (hit) begin done = 1; S_AXI_ARVALID = 1'b0; end
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    while (!got && lat < 20) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin got = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      @(posedge ACLK); #1;
      if (!got) lat++;
    end
    S_AXI_RREADY = 1'b0;
    if (!got) check("read_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge ACLK);
      if (pwm_out) c++;
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat, cnt, n;
    bit          prev, found;
    logic [14:0] samp, exp_samp;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                            S_AXI_RVALID, pwm_out, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'b111);
    @(posedge ACLK); #1;

    // Basic write then readback of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp);
      check($sformatf("bresp_%0d", i), resp, 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp, lat);
      check($sformatf("rdata_%0d", i), rd, 64'(i + 1));
      check($sformatf("rresp_%0d", i), resp, 64'd0);
    end
    check("read_latency", lat, 64'd0);

    // Byte strobes
    axi_write(4'hC, 32'h1122_3344, 4'hF, resp);
    axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, resp);
    axi_read(4'hC, rd, resp, lat);
    check("wstrb_merge", rd, 64'h1122_CC44);

    // W three cycles ahead of AW, BREADY held low for five cycles
    S_AXI_WDATA = 32'h5566_7788; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    check("w_held_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 64'b100);
    @(posedge ACLK); @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check($sformatf("b_hold_%0d", i), {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 64'b100);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("b_released", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 64'b011);
    @(posedge ACLK); #1;
    axi_read(4'hC, rd, resp, lat);
    check("split_write_data", rd, 64'h5566_7788);

    // PWM duty: CTRL is still 1 from the first block
    axi_write(4'h4, 32'd10, 4'hF, resp);
    axi_write(4'h8, 32'd3, 4'hF, resp);
    wait_cycles(25);
    count_high(30, cnt);
    check("duty_3_of_10", cnt, 64'd9);
    axi_write(4'h8, 32'd12, 4'hF, resp);
    wait_cycles(15);
    count_high(20, cnt);
    check("pulse_ge_period_high", cnt, 64'd20);
    axi_write(4'h4, 32'd0, 4'hF, resp);
    wait_cycles(15);
    count_high(20, cnt);
    check("period_zero_low", cnt, 64'd0);

    // Mid-period PULSE change committed while cnt goes 4 -> 5
    axi_write(4'h4, 32'd10, 4'hF, resp);
    axi_write(4'h8, 32'd3, 4'hF, resp);
    wait_cycles(25);
    prev = 1; found = 0; n = 0;
    while (!found && n < 40) begin
      @(negedge ACLK);
      if (!prev && pwm_out) found = 1;
      prev = pwm_out;
      n++;
    end
    check("phase_found", found, 64'd1);
    repeat (3) @(posedge ACLK);
    #1;
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'd7; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      samp[k-1] = pwm_out;
      exp_samp[k-1] = (Shadow && k <= 5) ? 1'b0 : (((4 + k) % 10) < 7);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    check("mid_period_pulse", samp, exp_samp);
    axi_read(4'h8, rd, resp, lat);
    check("pulse_readback", rd, 64'd7);

    // Reset pulse with a response pending and the output high
    axi_write(4'h8, 32'd12, 4'hF, resp);
    wait_cycles(15);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    check("pre_reset_state", {S_AXI_BVALID, pwm_out}, 64'b11);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_reset_state", {S_AXI_BVALID, pwm_out, S_AXI_RVALID}, 64'd0);
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp, lat);
      check($sformatf("reg_cleared_%0d", i), rd, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_axil_slave.md
# servo_axil_slave

AXI4-Lite responder for the servo PWM peripheral. It decodes master writes and reads into a bank of four 32-bit read/write registers and drives a single PWM output from those registers. It sits behind the interconnect, at the far end of the AXI4-Lite link from the VIP master. After a write, reads of the same address return the written value, masked by WSTRB.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width; bits [3:2] select the register.
- ACLK  in  1  single clock; all logic is on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- pwm_out  out  1  servo pulse output.

## Operation
- Register map:
  - 0x0 CTRL: bit0 is enable; all 32 bits are stored.
  - 0x4 PERIOD: period in ACLK cycles.
  - 0x8 PULSE: high time in ACLK cycles.
  - 0xC SCRATCH: plain storage.
- All registers read back exactly as stored.
- Write channel:
  - AW and W are accepted independently, in either order.
  - Each accepted channel is held in a one-entry buffer (aw_held, w_held).
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - On the edge where both address and data are available (buffered or handshaking in that cycle), the register is updated per byte lane where WSTRB[n]=1, and BVALID rises.
  - BVALID holds until BREADY; both buffers clear on the B handshake.
- Read channel:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA is captured and RVALID rises on the same edge.
  - RVALID/RDATA hold until RREADY.
- A read and a write to the same register on the same edge: the read returns the pre-write value.
- PWM generator:
  - A counter runs 0..PERIOD-1 while CTRL[0]=1 and PERIOD≠0; otherwise it is held at 0.
  - pwm_out = running && (cnt < PULSE).
  - PULSE ≥ PERIOD gives a constant high. PULSE=0 gives a constant low.
  - If PERIOD is reduced below the current count, the counter wraps to 0 on the next edge.

## Timing
- While ARESET=1, and on the first edge after it: every output is 0, all registers are 0, cnt=0, both buffers are empty.
- Ready signals assert on the first cycle after ARESET is released.
- Write latency: BVALID is high in the cycle after the later of the AW/W handshakes.
  - Back-to-back writes sustain one write per 2 cycles when BREADY is held high.
- Read latency: RVALID is high in the cycle after the AR handshake. Throughput is one read per 2 cycles.
- pwm_out is registered, one cycle behind cnt.
  - The first high cycle comes 2 edges after the enabling write commits.
- ARESET asserted mid-transaction drops BVALID/RVALID on that edge. The transaction is discarded with no response.

## Configuration
- SERVO_SHADOW_EN defined:
  - PERIOD and PULSE writes land in shadow registers; readback returns the shadow value.
  - Active copies load from the shadows when cnt = PERIOD_active−1 (period boundary), or at any cycle the counter is not running.
  - Waveform changes take effect only at period boundaries, with no glitches.
- Not defined: the generator uses the programmed registers directly, and changes take effect on the next edge.

## Structure
- Shared package servo_axil_pkg holds:
  - register offsets: ADDR_CTRL=2'd0, ADDR_PERIOD=2'd1, ADDR_PULSE=2'd2, ADDR_SCRATCH=2'd3;
  - AXI_RESP_OKAY=2'b00;
  - the ctrl_t bitfield struct.
- Sub-module servo_pwm_gen contains the counter, the comparator and the optional shadow logic.
- The top level contains the AXI FSMs and the register bank.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four back -> RDATA 1,2,3,4; every BRESP/RRESP is OKAY.
- Write SCRATCH=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0010 -> readback 0x1122CC44.
- WVALID 3 cycles before AWVALID, with BREADY held low 5 cycles -> one commit, BVALID held 5 cycles, AWREADY/WREADY low meanwhile, then ready again.
- Program PERIOD=10, PULSE=3, CTRL=1 -> pwm_out is high 3 of every 10 cycles.
  - PULSE=12 -> constant high.
  - PERIOD=0 -> constant low.
- Running PERIOD=10, PULSE=3; write PULSE=7 at cnt=5 -> the change appears in the next period with SERVO_SHADOW_EN, and in the current period (high at cnt=5,6) without it.
- Pulse ARESET while BVALID is pending and pwm_out=1 -> the next cycle shows BVALID=0, pwm_out=0, and all registers read 0.
